// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use and MDU stalls,
// branch flush, ALU operand forwarding, MDU busy tracking and a stall counter.
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             d_jtaken,
  input  logic             d_mdu,
  input  logic             d_hilo,
  input  logic [4:0]       ern,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       mrn,
  input  logic             mwreg,
  input  logic             mm2reg,
  output logic             wpcir,
  output logic             jflush,
  output logic             bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] BUSY_LOAD = 4'(MDU_LAT - 1);

  state_t     state;
  logic [3:0] busy_cnt;
  logic       lu;
  logic       mh;
  logic       stall;

  // EX loads are excluded from EX forwarding; the load-use stall covers them.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (ewreg && ern != 5'd0 && ern == src && !em2reg)
      fwd_sel = 2'b01;
    else if (mwreg && mrn != 5'd0 && mrn == src)
      fwd_sel = mm2reg ? 2'b11 : 2'b10;
    else
      fwd_sel = 2'b00;
  endfunction

  assign lu = ewreg & em2reg & (ern != 5'd0) &
              ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
  assign mh = (state == BUSY) & (d_mdu | d_hilo);
  assign stall = lu | mh;
  assign mdu_busy = (state == BUSY);

  // Reset forces the pipeline-facing outputs to their pass-through values.
  always_comb begin
    wpcir  = 1'b1;
    jflush = 1'b0;
    bubble = 1'b0;
    fwda   = 2'b00;
    fwdb   = 2'b00;
    if (resetn) begin
      wpcir  = ~stall;
      bubble = stall;
      jflush = ~stall & d_jtaken;
      fwda   = fwd_sel(rs);
      fwdb   = fwd_sel(rt);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      busy_cnt  <= 4'd0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_mdu && !stall) begin
            state    <= BUSY;
            busy_cnt <= BUSY_LOAD;
          end
        end
        BUSY: begin
          if (busy_cnt == 4'd1) begin
            state    <= IDLE;
            busy_cnt <= 4'd0;
          end else begin
            busy_cnt <= busy_cnt - 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          busy_cnt <= 4'd0;
        end
      endcase

      if (stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MDU_LAT=4, CNT_W=4).
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] rs = '0, rt = '0, ern = '0, mrn = '0;
  logic       use_rs = 0, use_rt = 0, d_jtaken = 0, d_mdu = 0, d_hilo = 0;
  logic       ewreg = 0, em2reg = 0, mwreg = 0, mm2reg = 0;
  logic       wpcir, jflush, bubble, mdu_busy;
  logic [1:0] fwda, fwdb;
  logic [3:0] stall_cnt;

  int total = 0;
  int fails = 0;

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clock(clock), .resetn(resetn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .d_jtaken(d_jtaken), .d_mdu(d_mdu), .d_hilo(d_hilo), .ern(ern), .ewreg(ewreg),
    .em2reg(em2reg), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg), .wpcir(wpcir),
    .jflush(jflush), .bubble(bubble), .fwda(fwda), .fwdb(fwdb), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    rs = 0; rt = 0; ern = 0; mrn = 0; use_rs = 0; use_rt = 0;
    d_jtaken = 0; d_mdu = 0; d_hilo = 0;
    ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
  endtask

  initial begin
    // Reset held with a load-use pattern present: outputs must stay forced.
    ewreg = 1; em2reg = 1; ern = 5; rs = 5; use_rs = 1; d_jtaken = 1;
    tick(); tick();
    chk("rst_wpcir", 32'(wpcir), 1);
    chk("rst_bubble", 32'(bubble), 0);
    chk("rst_jflush", 32'(jflush), 0);
    chk("rst_fwda", 32'(fwda), 0);
    chk("rst_busy", 32'(mdu_busy), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);

    // Load-use with a taken branch behind it.
    resetn = 1; #1;
    chk("lu_wpcir", 32'(wpcir), 0);
    chk("lu_bubble", 32'(bubble), 1);
    chk("lu_jflush", 32'(jflush), 0);
    tick();
    ern = 0; #1;
    chk("lu_rel_wpcir", 32'(wpcir), 1);
    chk("lu_rel_bubble", 32'(bubble), 0);
    chk("lu_rel_jflush", 32'(jflush), 1);
    chk("lu_rel_cnt", 32'(stall_cnt), 1);

    // Forwarding priority.
    clear_inputs();
    ewreg = 1; ern = 3; mwreg = 1; mm2reg = 1; mrn = 3; rs = 3; rt = 3; #1;
    chk("fwd_ex_a", 32'(fwda), 1);
    chk("fwd_ex_b", 32'(fwdb), 1);
    ewreg = 0; #1;
    chk("fwd_memld_a", 32'(fwda), 3);
    chk("fwd_memld_b", 32'(fwdb), 3);
    mm2reg = 0; #1;
    chk("fwd_mem_a", 32'(fwda), 2);
    chk("fwd_mem_b", 32'(fwdb), 2);
    ewreg = 1; em2reg = 1; mwreg = 0; #1;
    chk("fwd_exld_a", 32'(fwda), 0);
    em2reg = 0; rs = 0; rt = 0; ern = 0; mwreg = 1; mrn = 0; #1;
    chk("fwd_r0_a", 32'(fwda), 0);
    chk("fwd_r0_b", 32'(fwdb), 0);
    rt = 7; ern = 7; #1;
    chk("fwd_split_a", 32'(fwda), 0);
    chk("fwd_split_b", 32'(fwdb), 1);

    // MDU issue at T together with a taken branch.
    clear_inputs();
    d_mdu = 1; d_jtaken = 1; #1;
    chk("mdu_T_wpcir", 32'(wpcir), 1);
    chk("mdu_T_jflush", 32'(jflush), 1);
    chk("mdu_T_busy", 32'(mdu_busy), 0);
    tick();
    d_mdu = 0; d_jtaken = 0; d_hilo = 1; #1;
    chk("mdu_T1_busy", 32'(mdu_busy), 1);
    chk("mdu_T1_wpcir", 32'(wpcir), 0);
    tick();
    chk("mdu_T2_wpcir", 32'(wpcir), 0);
    tick();
    chk("mdu_T3_wpcir", 32'(wpcir), 0);
    chk("mdu_T3_busy", 32'(mdu_busy), 1);
    tick();
    chk("mdu_T4_busy", 32'(mdu_busy), 0);
    chk("mdu_T4_wpcir", 32'(wpcir), 1);
    chk("mdu_T4_cnt", 32'(stall_cnt), 4);

    // Back-to-back MDU op, then reset one cycle after issue.
    d_hilo = 0; d_mdu = 1; #1;
    chk("mdu2_issue_wpcir", 32'(wpcir), 1);
    tick();
    chk("mdu2_busy", 32'(mdu_busy), 1);
    chk("mdu2_stalled", 32'(wpcir), 0);
    #2 resetn = 0; #1;
    chk("midrst_busy", 32'(mdu_busy), 0);
    chk("midrst_cnt", 32'(stall_cnt), 0);
    chk("midrst_wpcir", 32'(wpcir), 1);

    // Saturation: hold a load-use stall for 20 cycles.
    clear_inputs();
    tick();
    #2 resetn = 1;
    ewreg = 1; em2reg = 1; ern = 9; rt = 9; use_rt = 1;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(stall_cnt), 14);
    tick(); tick();
    chk("sat_16", 32'(stall_cnt), 15);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_20", 32'(stall_cnt), 15);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Produces the IF/ID write enable (wpcir), the IF/ID jump-flush request (jflush), the ID/EX bubble insert, and the ALU operand forwarding selects.
- Tracks an in-flight multicycle multiply/divide (MDU) op with a busy state machine, and keeps a saturating stall-cycle performance counter.
- Sits in the ID stage beside the control unit; its outputs drive the PC register, the IF/ID register and the ID/EX register.

Parameters:
MDU_LAT, 4, cycles the MDU is busy after an op issues (legal range 2..15)
CNT_W, 32, width of the stall performance counter

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
rs  in  5  ID source register A
rt  in  5  ID source register B
use_rs  in  1  ID instruction reads rs
use_rt  in  1  ID instruction reads rt
d_jtaken  in  1  ID branch/jump resolved taken
d_mdu  in  1  ID instruction is an MDU op (mult/div)
d_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
ern  in  5  EX destination register
ewreg  in  1  EX writes register file
em2reg  in  1  EX instruction is a load
mrn  in  5  MEM destination register
mwreg  in  1  MEM writes register file
mm2reg  in  1  MEM instruction is a load
wpcir  out  1  1 = PC and IF/ID advance; 0 = hold
jflush  out  1  squash the instruction fetched behind a taken branch
bubble  out  1  load a NOP into ID/EX this cycle
fwda  out  2  operand A select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
fwdb  out  2  operand B select, same encoding, against rt
mdu_busy  out  1  MDU state is BUSY
stall_cnt  out  CNT_W  total stalled cycles since reset

Behaviour:
- Reset (resetn=0, asynchronous):
  - state = IDLE, busy counter = 0, stall_cnt = 0.
  - While reset is held, outputs are forced to wpcir=1, jflush=0, bubble=0, fwda=fwdb=00, mdu_busy=0.
- Load-use hazard, combinational:
  - lu = ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- MDU hazard, combinational:
  - mh = (state==BUSY) & (d_mdu | d_hilo).
- Stall = lu | mh. When stalled: wpcir=0, bubble=1, jflush=0.
  - A taken branch is not flushed while stalled; it re-evaluates on the cycle it finally advances.
- No stall: wpcir=1, bubble=0, jflush=d_jtaken.
- Forwarding, for each operand X in {rs, rt}, in priority order:
  - EX match (ewreg & ern!=0 & ern==X & ~em2reg) -> 01.
  - else MEM match (mwreg & mrn!=0 & mrn==X) -> 10 if ~mm2reg, 11 if mm2reg.
  - else 00.
  - Register 0 never forwards.
  - An EX-stage load match yields 00; it is covered by the lu stall.
- MDU FSM, states IDLE and BUSY:
  - IDLE -> BUSY when d_mdu & ~stall at the clock edge (op issues). Counter loads MDU_LAT-1.
  - BUSY: counter decrements each cycle. When counter==1, next state is IDLE and counter becomes 0.
  - Result: BUSY lasts exactly MDU_LAT-1 cycles after issue, and the MDU result is readable on the MDU_LAT-th cycle after issue.
  - A back-to-back d_mdu is stalled while BUSY and issues on the first IDLE cycle it sees.
  - mdu_busy = (state==BUSY).
- stall_cnt:
  - Increments on every rising edge where wpcir==0.
  - Saturates at all-ones and never wraps.
- Simultaneous events:
  - lu and mh together count as a single stall cycle.
  - d_jtaken with d_mdu issuing: the MDU op issues and jflush=1 in the same cycle.
- Reset mid-operation: BUSY aborts to IDLE immediately and stall_cnt clears; no partial state survives.

Test Plan:
- Load-use: EX lw to r5 (ewreg=1, em2reg=1, ern=5), ID add using rs=5, use_rs=1 -> wpcir=0, bubble=1 for exactly 1 cycle; the following cycle with ern=0 gives wpcir=1 and stall_cnt=1.
- Forwarding: ern=3 ALU write and mrn=3 load write, rs=rt=3 -> fwda=fwdb=01. With ewreg=0 -> 11. With mm2reg=0 -> 10. With rs=0 and matching ern=0 -> 00.
- MDU: d_mdu issues at cycle T, next ID has d_hilo=1 -> wpcir=0 for cycles T+1..T+3 (MDU_LAT=4), wpcir=1 at T+4, mdu_busy falls at T+4.
- Branch: d_jtaken=1 with no hazard -> jflush=1. d_jtaken=1 during a load-use stall -> jflush=0, then jflush=1 on the release cycle.
- Saturation: with CNT_W=4, hold a stall for 20 cycles -> stall_cnt reaches 15 and stays 15.
- Reset mid-BUSY: assert resetn=0 one cycle after issue -> mdu_busy=0, stall_cnt=0 and wpcir=1 immediately, without waiting for a clock edge.
